// File: rtl/imm_split.sv
// imm_split: splits a 32-bit constant into the one or two immediate beats
// needed to rebuild it through the 12-bit / 20-bit sign-extension path.
// A rebuilt value satisfies (sext20(hi) << 12) + sext12(lo) == value (mod 2^32).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_value holds a constant
//   in_ready   block can take a constant this cycle (combinational)
//   in_value   32-bit constant to decompose
//   out_valid  an output beat is held
//   out_ready  consumer takes the beat
//   out_imm    field bits: {8'b0, lo12} for a lo beat, hi20 for a hi beat
//   out_type   0 = 12-bit lo field, 1 = 20-bit hi field
//   out_last   final beat for the current constant
module imm_split (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_imm,
  output logic        out_type,
  output logic        out_last
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,  // no beat held
    S_FINAL = 2'd1,  // holding a last=1 beat
    S_HI    = 2'd2   // holding a hi beat, lo parked
  } state_t;

  state_t      state_reg, state_next;
  logic [19:0] imm_reg, imm_next;
  logic        type_reg, type_next;
  logic [11:0] lo_park_reg, lo_park_next;

  logic        in_xfer;
  logic        out_xfer;
  logic        is_short;
  logic        lo_zero;
  logic [19:0] hi_rounded;

  // Valid and last fall straight out of the state register, so they are
  // registered outputs and reset cleanly with the state.
  assign out_valid = (state_reg != S_EMPTY);
  assign out_last  = (state_reg == S_FINAL);
  assign out_imm   = imm_reg;
  assign out_type  = type_reg;

  assign in_ready = (state_reg == S_EMPTY) || ((state_reg == S_FINAL) && out_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // A value fits the signed 12-bit lo field when bits 31..11 are pure sign.
  assign is_short = (in_value[31:11] == 21'h000000) || (in_value[31:11] == 21'h1FFFFF);
  assign lo_zero  = (in_value[11:0] == 12'h000);

  // (v + 0x800)[31:12]: the low 12 bits of 0x800 only contribute a carry
  // into bit 12 when v[11] is set, so add that bit to the upper field.
  // This compensates for sext12(lo) being negative when lo[11] is set.
  assign hi_rounded = in_value[31:12] + {19'b0, in_value[11]};

  always_comb begin
    state_next   = state_reg;
    imm_next     = imm_reg;
    type_next    = type_reg;
    lo_park_next = lo_park_reg;

    unique case (state_reg)
      S_EMPTY: begin
        // handled by the shared load below
      end
      S_FINAL: begin
        if (out_xfer && !in_xfer) begin
          state_next = S_EMPTY;
        end
      end
      S_HI: begin
        if (out_xfer) begin
          state_next = S_FINAL;
          imm_next   = {8'b0, lo_park_reg};
          type_next  = 1'b0;
        end
      end
      default: begin
        state_next = S_EMPTY;
      end
    endcase

    // in_ready already restricts transfers to EMPTY, or FINAL while the
    // held beat leaves, so a load always overrides the hold/drain above.
    if (in_xfer) begin
      if (is_short) begin
        state_next = S_FINAL;
        imm_next   = {8'b0, in_value[11:0]};
        type_next  = 1'b0;
      end else if (lo_zero) begin
        state_next = S_FINAL;
        imm_next   = in_value[31:12];
        type_next  = 1'b1;
      end else begin
        state_next   = S_HI;
        imm_next     = hi_rounded;
        type_next    = 1'b1;
        lo_park_next = in_value[11:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_EMPTY;
      imm_reg     <= 20'h00000;
      type_reg    <= 1'b0;
      lo_park_reg <= 12'h000;
    end else begin
      state_reg   <= state_next;
      imm_reg     <= imm_next;
      type_reg    <= type_next;
      lo_park_reg <= lo_park_next;
    end
  end

endmodule

// File: tb/tb_imm_split.sv
module tb_imm_split;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_imm;
  logic        out_type;
  logic        out_last;

  imm_split dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_type  (out_type),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // expected beat packed as {type, last, imm}
  logic [21:0] exp_q[$];
  int          pop_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: sample away from the active edge; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got type=%0d imm=0x%05h last=%0d with nothing expected",
                 out_type, out_imm, out_last);
      end else begin
        logic [21:0] e;
        e = exp_q.pop_front();
        $display("beat: type=%0d imm=0x%05h last=%0d (expected type=%0d imm=0x%05h last=%0d)",
                 out_type, out_imm, out_last, e[21], e[19:0], e[20]);
        check("beat_imm",  {12'b0, out_imm},  {12'b0, e[19:0]});
        check("beat_type", {31'b0, out_type}, {31'b0, e[21]});
        check("beat_last", {31'b0, out_last}, {31'b0, e[20]});
        pop_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [21:0] beat(input logic typ, input logic last, input logic [19:0] imm);
    return {typ, last, imm};
  endfunction

  // Called just after a posedge; returns just after the posedge of the transfer.
  task automatic send(input logic [31:0] v, input int nbeats,
                      input logic [21:0] b0, input logic [21:0] b1, input logic expect_ready_now);
    int waited;
    in_valid = 1'b1;
    in_value = v;
    @(negedge clk);
    if (expect_ready_now) check("in_ready_at_offer", {31'b0, in_ready}, 32'd1);
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=0 after 20 cycles, required 1");
    end else begin
      if (nbeats >= 1) exp_q.push_back(b0);
      if (nbeats >= 2) exp_q.push_back(b1);
      $display("accept: value=0x%08h beats=%0d", v, nbeats);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] v;
    int          n;
    logic [21:0] b0;
    logic [21:0] b1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h000007FF, 1, beat(1'b0, 1'b1, 20'h007FF), 22'h0};
    vecs[1] = '{32'hFFFFF800, 1, beat(1'b0, 1'b1, 20'h00800), 22'h0};
    vecs[2] = '{32'h12345678, 2, beat(1'b1, 1'b0, 20'h12345), beat(1'b0, 1'b1, 20'h00678)};
    vecs[3] = '{32'h12345800, 2, beat(1'b1, 1'b0, 20'h12346), beat(1'b0, 1'b1, 20'h00800)};
    vecs[4] = '{32'h7FFFF800, 2, beat(1'b1, 1'b0, 20'h80000), beat(1'b0, 1'b1, 20'h00800)};
    vecs[5] = '{32'h00001000, 1, beat(1'b1, 1'b1, 20'h00001), 22'h0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_value  = 32'hDEADBEEF;
    out_ready = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_imm",   {12'b0, out_imm},   32'd0);
    check("rst_out_type",  {31'b0, out_type},  32'd0);
    check("rst_out_last",  {31'b0, out_last},  32'd0);
    check("rst_in_ready",  {31'b0, in_ready},  32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vectors, first beat one cycle after accept
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].v, vecs[i].n, vecs[i].b0, vecs[i].b1, 1'b1);
      @(negedge clk);
      check("latency_out_valid", {31'b0, out_valid}, 32'd1);
      drain();
    end

    // hi beat held under backpressure, then reset drops it
    out_ready = 1'b0;
    send(32'h12345678, 0, 22'h0, 22'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid",    {31'b0, out_valid}, 32'd1);
      check("stall_imm",      {12'b0, out_imm},   32'h12345);
      check("stall_type",     {31'b0, out_type},  32'd1);
      check("stall_last",     {31'b0, out_last},  32'd0);
      check("stall_in_ready", {31'b0, in_ready},  32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("postrst_out_valid", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // back-to-back short constants
    pop_cyc.delete();
    send(32'h00000001, 1, beat(1'b0, 1'b1, 20'h00001), 22'h0, 1'b1);
    send(32'h00000002, 1, beat(1'b0, 1'b1, 20'h00002), 22'h0, 1'b1);
    send(32'h00000003, 1, beat(1'b0, 1'b1, 20'h00003), 22'h0, 1'b1);
    drain();
    check("b2b_beat_count", pop_cyc.size(), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap_1", pop_cyc[1] - pop_cyc[0], 32'd1);
      check("b2b_gap_2", pop_cyc[2] - pop_cyc[1], 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
